// File: rtl/sr_ccu_sched.sv
// sr_ccu_sched: non-blocking issue/retire scheduler for the multi-cycle CCU.
// Launches one CCU op, lets the core run on, stalls only on hazards against
// the pending destination or on a second CCU issue, and takes over the
// register-file write port for the single retire (WB) cycle.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   issue_valid/rd/a/b              CCU instruction from decode
//   rs1, rs2, cur_rd, cur_we        register usage of the current instr
//   cpu_wd                          core writeback data
//   stall                           hold PC / inject NOP this cycle
//   fu_rst, fu_start, fu_a, fu_b    functional unit control and operands
//   fu_done, fu_result              functional unit completion
//   rf_we, rf_wa, rf_wd             muxed register-file write port
//   busy, err, err_clr              status, sticky timeout flag and clear
module sr_ccu_sched #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [DATA_W-1:0] issue_a,
    input  logic [DATA_W-1:0] issue_b,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] cur_rd,
    input  logic              cur_we,
    input  logic [DATA_W-1:0] cpu_wd,
    output logic              stall,
    output logic              fu_rst,
    output logic              fu_start,
    output logic [DATA_W-1:0] fu_a,
    output logic [DATA_W-1:0] fu_b,
    input  logic              fu_done,
    input  logic [DATA_W-1:0] fu_result,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              busy,
    output logic              err,
    input  logic              err_clr
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WB
    } state_t;

    // Counter just wide enough to reach TIMEOUT-1.
    localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] CNT_LAST = CW'(TLIM);

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic              pend_valid;
    logic [REG_AW-1:0] pend_rd;
    logic [DATA_W-1:0] res;
    logic              accept;
    logic              tmo;
    logic              hazard;

    // x0 never creates a hazard: writes to it are discarded.
    always_comb begin
        hazard = pend_valid && (pend_rd != '0) &&
                 ((rs1 == pend_rd) || (rs2 == pend_rd) ||
                  (cur_we && (cur_rd == pend_rd)));
    end

    always_comb begin
        state_nxt = state;
        stall     = hazard;
        accept    = 1'b0;
        tmo       = 1'b0;
        fu_rst    = 1'b1;
        rf_we     = cur_we;
        rf_wa     = cur_rd;
        rf_wd     = cpu_wd;
        busy      = (state != IDLE);
        // Only one CCU op may be in flight.
        if (issue_valid && (state != IDLE)) begin
            stall = 1'b1;
        end
        unique case (state)
            IDLE: begin
                if (issue_valid && !hazard) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                fu_rst = 1'b0;
                // A completion in the last allowed cycle beats the timeout.
                if (fu_done) begin
                    state_nxt = (pend_rd != '0) ? WB : IDLE;
                end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                    tmo       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WB: begin
                stall     = 1'b1;
                rf_we     = 1'b1;
                rf_wa     = pend_rd;
                rf_wd     = res;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_rd    <= '0;
            fu_start   <= 1'b0;
            fu_a       <= '0;
            fu_b       <= '0;
            res        <= '0;
            cnt        <= '0;
            err        <= 1'b0;
        end else begin
            fu_start <= accept;
            if (accept) begin
                fu_a       <= issue_a;
                fu_b       <= issue_b;
                pend_rd    <= issue_rd;
                pend_valid <= (issue_rd != '0);
                cnt        <= '0;
            end
            if (state == RUN) begin
                cnt <= cnt + CW'(1);
                if (fu_done) begin
                    res <= fu_result;
                end
            end
            if ((state == WB) || tmo) begin
                pend_valid <= 1'b0;
            end
            // A timeout in the same cycle as a clear leaves err set.
            if (err_clr) begin
                err <= 1'b0;
            end
            if (tmo) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sr_ccu_sched.sv
// tb_sr_ccu_sched: directed bench for sr_ccu_sched with a write-port
// scoreboard; expected register-file writes are queued by the stimulus.
module tb_sr_ccu_sched;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic [DW-1:0] issue_a;
    logic [DW-1:0] issue_b;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] cur_rd;
    logic          cur_we;
    logic [DW-1:0] cpu_wd;
    logic          stall;
    logic          fu_rst;
    logic          fu_start;
    logic [DW-1:0] fu_a;
    logic [DW-1:0] fu_b;
    logic          fu_done;
    logic [DW-1:0] fu_result;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic          busy;
    logic          err;
    logic          err_clr;

    sr_ccu_sched #(
        .DATA_W (DW),
        .REG_AW (AW),
        .TIMEOUT(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .issue_a    (issue_a),
        .issue_b    (issue_b),
        .rs1        (rs1),
        .rs2        (rs2),
        .cur_rd     (cur_rd),
        .cur_we     (cur_we),
        .cpu_wd     (cpu_wd),
        .stall      (stall),
        .fu_rst     (fu_rst),
        .fu_start   (fu_start),
        .fu_a       (fu_a),
        .fu_b       (fu_b),
        .fu_done    (fu_done),
        .fu_result  (fu_result),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .busy       (busy),
        .err        (err),
        .err_clr    (err_clr)
    );

    typedef struct {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } wr_t;

    wr_t q[$];
    int  checks = 0;
    int  errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        wr_t e;
        e.wa = wa;
        e.wd = wd;
        q.push_back(e);
    endtask

    // Monitor: every register-file write must match the next queued entry.
    always begin
        wr_t e;
        @(negedge clk);
        #3;
        if (rst_n && rf_we) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got wa=%0d wd=%h expected none",
                         rf_wa, rf_wd);
            end else begin
                e = q.pop_front();
                chk("wr_addr", 32'(rf_wa), 32'(e.wa));
                chk("wr_data", rf_wd, e.wd);
            end
        end
    end

    // Leaves the bench in the first RUN cycle (T+1), 2 units past negedge.
    task automatic issue_op(input logic [AW-1:0] rd, input logic [DW-1:0] a,
                            input logic [DW-1:0] b);
        @(negedge clk);
        issue_valid = 1'b1;
        issue_rd    = rd;
        issue_a     = a;
        issue_b     = b;
        #2;
        chk("issue_stall", 32'(stall), 32'd0);
        @(negedge clk);
        issue_valid = 1'b0;
        #2;
        chk("fu_start_t1", 32'(fu_start), 32'd1);
        chk("fu_a", fu_a, a);
        chk("fu_b", fu_b, b);
        chk("busy_run", 32'(busy), 32'd1);
        chk("fu_rst_run", 32'(fu_rst), 32'd0);
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        issue_a     = '0;
        issue_b     = '0;
        rs1         = '0;
        rs2         = '0;
        cur_rd      = '0;
        cur_we      = 1'b0;
        cpu_wd      = '0;
        fu_done     = 1'b0;
        fu_result   = '0;
        err_clr     = 1'b0;
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fu_rst", 32'(fu_rst), 32'd1);
        chk("rst_fu_start", 32'(fu_start), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // 1: basic issue, done in 4th RUN cycle, one WB cycle.
        issue_op(5'd5, 32'd7, 32'd3);
        step();
        chk("t1_fu_start_t2", 32'(fu_start), 32'd0);
        step();
        step();
        fu_done   = 1'b1;
        fu_result = 32'hA;
        push(5'd5, 32'hA);
        step();
        fu_done = 1'b0;
        chk("t1_wb_stall", 32'(stall), 32'd1);
        chk("t1_wb_we", 32'(rf_we), 32'd1);
        step();
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_idle_stall", 32'(stall), 32'd0);
        chk("t1_idle_fu_rst", 32'(fu_rst), 32'd1);

        // fu_done while idle is ignored.
        fu_done   = 1'b1;
        fu_result = 32'hDEAD;
        step();
        fu_done = 1'b0;
        chk("idle_done_busy", 32'(busy), 32'd0);

        // 2: independent instr runs alongside; core write passes the mux.
        issue_op(5'd5, 32'd1, 32'd2);
        rs1    = 5'd2;
        rs2    = 5'd3;
        cur_rd = 5'd4;
        cur_we = 1'b1;
        cpu_wd = 32'h1234;
        push(5'd4, 32'h1234);
        #1;
        chk("t2_indep_stall", 32'(stall), 32'd0);
        step();
        cur_we    = 1'b0;
        fu_done   = 1'b1;
        fu_result = 32'h55;
        push(5'd5, 32'h55);
        step();
        fu_done = 1'b0;
        rs1     = '0;
        rs2     = '0;
        cur_rd  = '0;
        step();

        // 3: read-after-pending hazard holds until WB completes.
        issue_op(5'd5, 32'd1, 32'd2);
        rs2 = 5'd5;
        #1;
        chk("t3_haz_t1", 32'(stall), 32'd1);
        step();
        chk("t3_haz_t2", 32'(stall), 32'd1);
        fu_done   = 1'b1;
        fu_result = 32'h3;
        push(5'd5, 32'h3);
        step();
        fu_done = 1'b0;
        chk("t3_haz_wb", 32'(stall), 32'd1);
        step();
        chk("t3_after_wb", 32'(stall), 32'd0);
        rs2 = '0;

        // 4: second CCU issue stalls until the cycle after WB.
        issue_op(5'd6, 32'd1, 32'd1);
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        issue_a     = 32'd9;
        issue_b     = 32'd11;
        #1;
        chk("t4_struct_t1", 32'(stall), 32'd1);
        step();
        chk("t4_struct_t2", 32'(stall), 32'd1);
        fu_done   = 1'b1;
        fu_result = 32'h20;
        push(5'd6, 32'h20);
        step();
        fu_done = 1'b0;
        chk("t4_struct_wb", 32'(stall), 32'd1);
        step();
        chk("t4_accept_stall", 32'(stall), 32'd0);
        chk("t4_accept_busy", 32'(busy), 32'd0);
        @(negedge clk);
        issue_valid = 1'b0;
        #2;
        chk("t4_fu_start2", 32'(fu_start), 32'd1);
        chk("t4_fu_a2", fu_a, 32'd9);
        chk("t4_fu_b2", fu_b, 32'd11);
        fu_done   = 1'b1;
        fu_result = 32'h30;
        push(5'd7, 32'h30);
        step();
        fu_done = 1'b0;
        step();

        // 5: timeout after 8 RUN cycles, no write, err sticky.
        issue_op(5'd9, 32'd4, 32'd4);
        for (int i = 2; i <= 8; i++) begin
            step();
            chk("t5_run_busy", 32'(busy), 32'd1);
            chk("t5_run_err", 32'(err), 32'd0);
        end
        step();
        chk("t5_tmo_err", 32'(err), 32'd1);
        chk("t5_tmo_busy", 32'(busy), 32'd0);
        chk("t5_tmo_fu_rst", 32'(fu_rst), 32'd1);
        rs1 = 5'd9;
        #1;
        chk("t5_tmo_nohaz", 32'(stall), 32'd0);
        rs1 = '0;

        // clear coinciding with a second timeout leaves err set.
        issue_op(5'd9, 32'd4, 32'd4);
        for (int i = 2; i <= 8; i++) begin
            step();
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("t5_clr_tmo_err", 32'(err), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("t5_clr_err", 32'(err), 32'd0);

        // done and timeout in the same cycle: done wins.
        issue_op(5'd10, 32'd2, 32'd2);
        for (int i = 2; i <= 8; i++) begin
            step();
        end
        fu_done   = 1'b1;
        fu_result = 32'h77;
        push(5'd10, 32'h77);
        step();
        fu_done = 1'b0;
        chk("t5_race_wb", 32'(busy), 32'd1);
        chk("t5_race_err", 32'(err), 32'd0);
        step();

        // 6: rd=x0 runs without WB or hazard.
        issue_op(5'd0, 32'd1, 32'd1);
        #1;
        chk("t6_x0_nohaz", 32'(stall), 32'd0);
        fu_done   = 1'b1;
        fu_result = 32'h99;
        step();
        fu_done = 1'b0;
        chk("t6_x0_nowb", 32'(busy), 32'd0);

        // async reset mid-RUN.
        issue_op(5'd12, 32'h5A, 32'hA5);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_fu_start", 32'(fu_start), 32'd0);
        chk("t6_rst_fu_a", fu_a, 32'd0);
        chk("t6_rst_fu_rst", 32'(fu_rst), 32'd1);
        chk("t6_rst_err", 32'(err), 32'd0);
        step();
        rst_n = 1'b1;
        rs1   = 5'd12;
        step();
        chk("t6_post_rst_stall", 32'(stall), 32'd0);
        chk("t6_post_rst_busy", 32'(busy), 32'd0);
        step();

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
